vga_pattern_sequencer: RTL
==========================

// Module: vga_pattern_sequencer
// PURPOSE
//  Colour-source controller for the VGA driver. Tracks the driver's HSync/VSync
//  outputs to recover frame, line and column position, and drives the driver's
//  2-bit Red/Green/Blue inputs. Steps through a fixed set of test patterns,
//  changing pattern only on frame boundaries.
// PARAMETERS
//  FRAMES_PER_PATTERN  60  frames shown per pattern before advancing (>=1)
//  BAR_SHIFT           7   col_cnt bit that starts the 3-bit bar index
//  COL_W               11  column counter width (clk cycles per line)
//  LINE_W              10  line counter width
// PORTS
//  clk          in   1      system clock
//  reset        in   1      async, active-high reset
//  HSync        in   1      from VGA driver; active-low pulse
//  VSync        in   1      from VGA driver; active-low pulse
//  hold         in   1      1 = freeze pattern index and frame count
//  Red          out  2      colour to VGA driver
//  Green        out  2      colour to VGA driver
//  Blue         out  2      colour to VGA driver
//  pattern_idx  out  3      current pattern number
//  running      out  1      1 once the first frame boundary has been seen
// BEHAVIOUR
//  - Reset: Red/Green/Blue=0, pattern_idx=0, running=0, frame_cnt=0, line_cnt=0,
//    col_cnt=0, FSM=IDLE; sync history flops=1 (idle-high).
//  - Edge detect: one history flop per sync input. hfall = hs_q & ~HSync;
//    vfall = vs_q & ~VSync. Inputs are synchronous to clk; no synchroniser.
//  - FSM IDLE: colours forced to 0. On vfall -> RUN, running=1, pattern_idx=0,
//    frame_cnt=0.
//  - FSM RUN: stays in RUN until reset. There is no exit path.
//  - col_cnt: cleared on hfall, otherwise +1, saturating at all-ones.
//  - line_cnt: cleared on vfall; +1 on hfall, saturating.
//  - Simultaneous vfall and hfall: vfall wins; line_cnt=0 and col_cnt=0.
//  - Frame advance (RUN, vfall, hold=0):
//    - frame_cnt==FRAMES_PER_PATTERN-1 -> frame_cnt=0 and pattern_idx advances.
//      pattern_idx wraps from the last pattern to 0.
//    - otherwise frame_cnt+1.
//  - hold=1: frame_cnt and pattern_idx unchanged; position counters still run.
//  - Patterns (bar index b = col_cnt[BAR_SHIFT+:3]):
//    - 0 solid red: R=3,G=0,B=0
//    - 1 solid green: R=0,G=3,B=0
//    - 2 solid blue: R=0,G=0,B=3
//    - 3 colour bars: R={2{b[2]}}, G={2{b[1]}}, B={2{b[0]}}
//  - Colour outputs are registered: one clk of latency from counter/index update.
//  - Reset mid-frame: all state returns to reset values immediately (async).
//    Output resumes only after the next vfall.
// CONFIGURATION
//  VGA_SEQ_CHECKER_EN
//    - Defined: adds pattern 4, checkerboard: c = line_cnt[5]^col_cnt[BAR_SHIFT];
//      R=G=B={2{c}}. pattern_idx wraps 4 -> 0.
//    - Undefined: 4 patterns only; pattern_idx wraps 3 -> 0; value 4 never occurs.
// TESTING
//  - Reset, then HSync/VSync toggling with no vfall:
//    -> RGB=0, running=0, pattern_idx=0.
//  - FRAMES_PER_PATTERN=2, first vfall:
//    -> running=1, pattern 0, RGB=(3,0,0) one clk later.
//    2 further vfalls -> pattern_idx=1, RGB=(0,3,0).
//  - Pattern 3, BAR_SHIFT=2: hfall, then count cycles:
//    -> col_cnt 0..3 gives RGB=(0,0,0); col_cnt 28..31 gives RGB=(3,3,3).
//  - hold=1 across 5 vfalls:
//    -> pattern_idx unchanged. Release: advances after 2 more vfalls.
//  - Wrap: cycle through all patterns:
//    -> idx 3 -> 0 without macro; 3 -> 4 -> 0 with VGA_SEQ_CHECKER_EN.
//  - Simultaneous hfall+vfall -> line_cnt=0, col_cnt=0.
//    Assert reset mid-line -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/vga_pattern_sequencer_if.sv
// VGA sequencer bus: sync inputs and hold from the driver side, colour/status back.
// master = VGA driver / stimulus side, slave = pattern sequencer.
interface vga_pattern_sequencer_if;
  logic       HSync;
  logic       VSync;
  logic       hold;
  logic [1:0] Red;
  logic [1:0] Green;
  logic [1:0] Blue;
  logic [2:0] pattern_idx;
  logic       running;

  modport master (
    output HSync, VSync, hold,
    input  Red, Green, Blue, pattern_idx, running
  );

  modport slave (
    input  HSync, VSync, hold,
    output Red, Green, Blue, pattern_idx, running
  );
endinterface

// File: rtl/vga_pattern_sequencer.sv
// Colour-source controller for the VGA driver. Recovers line/column position from
// the driver's active-low HSync/VSync and steps through test patterns on frame
// boundaries. Optional checkerboard pattern 4 is enabled by VGA_SEQ_CHECKER_EN.
module vga_pattern_sequencer #(
  parameter int unsigned FRAMES_PER_PATTERN = 60,
  parameter int unsigned BAR_SHIFT          = 7,
  parameter int unsigned COL_W              = 11,
  parameter int unsigned LINE_W             = 10
) (
  input logic                    clk,
  input logic                    reset,
  vga_pattern_sequencer_if.slave bus
);

  localparam int unsigned FRAME_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
`ifdef VGA_SEQ_CHECKER_EN
  localparam int unsigned NUM_PAT = 5;
`else
  localparam int unsigned NUM_PAT = 4;
`endif

  typedef enum logic [0:0] {IDLE, RUN} state_e;

  state_e              state_q, state_d;
  logic                running_q, running_d;
  logic [2:0]          pattern_idx_q, pattern_idx_d;
  logic [FRAME_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [COL_W-1:0]    col_cnt_q, col_cnt_d;
  logic [LINE_W-1:0]   line_cnt_q, line_cnt_d;
  logic                hs_q, vs_q;
  logic [1:0]          red_q, red_d;
  logic [1:0]          green_q, green_d;
  logic [1:0]          blue_q, blue_d;
  logic [2:0]          bar_c;
  logic                hfall_c;
  logic                vfall_c;
`ifdef VGA_SEQ_CHECKER_EN
  logic                checker_c;
`endif

  assign hfall_c = hs_q & ~bus.HSync;
  assign vfall_c = vs_q & ~bus.VSync;

  // Sync history flops idle high so a low input straight after reset reads as a fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      hs_q <= bus.HSync;
      vs_q <= bus.VSync;
    end
  end

  // Position counters: vfall restarts the line count, hfall restarts the column.
  always_comb begin
    col_cnt_d  = col_cnt_q;
    line_cnt_d = line_cnt_q;
    if (hfall_c) begin
      col_cnt_d = '0;
    end else if (col_cnt_q != '1) begin
      col_cnt_d = col_cnt_q + COL_W'(1);
    end
    if (vfall_c) begin
      line_cnt_d = '0;
    end else if (hfall_c && (line_cnt_q != '1)) begin
      line_cnt_d = line_cnt_q + LINE_W'(1);
    end
  end

  // FSM state and frame/pattern registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      running_q     <= 1'b0;
      pattern_idx_q <= '0;
      frame_cnt_q   <= '0;
      col_cnt_q     <= '0;
      line_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      running_q     <= running_d;
      pattern_idx_q <= pattern_idx_d;
      frame_cnt_q   <= frame_cnt_d;
      col_cnt_q     <= col_cnt_d;
      line_cnt_q    <= line_cnt_d;
    end
  end

  // Next state: first vfall starts the sequence, later vfalls count frames.
  always_comb begin
    state_d       = state_q;
    running_d     = running_q;
    pattern_idx_d = pattern_idx_q;
    frame_cnt_d   = frame_cnt_q;
    case (state_q)
      IDLE: begin
        if (vfall_c) begin
          state_d       = RUN;
          running_d     = 1'b1;
          pattern_idx_d = '0;
          frame_cnt_d   = '0;
        end
      end
      RUN: begin
        if (vfall_c && !bus.hold) begin
          if (frame_cnt_q == FRAME_W'(FRAMES_PER_PATTERN - 1)) begin
            frame_cnt_d   = '0;
            pattern_idx_d = (pattern_idx_q == 3'(NUM_PAT - 1)) ? 3'd0
                                                               : pattern_idx_q + 3'd1;
          end else begin
            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Colour generation from current position and pattern; black until running.
  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    bar_c   = col_cnt_q[BAR_SHIFT +: 3];
`ifdef VGA_SEQ_CHECKER_EN
    checker_c = line_cnt_q[5] ^ col_cnt_q[BAR_SHIFT];
`endif
    if (state_q == RUN) begin
      case (pattern_idx_q)
        3'd0: red_d   = 2'b11;
        3'd1: green_d = 2'b11;
        3'd2: blue_d  = 2'b11;
        3'd3: begin
          red_d   = {2{bar_c[2]}};
          green_d = {2{bar_c[1]}};
          blue_d  = {2{bar_c[0]}};
        end
`ifdef VGA_SEQ_CHECKER_EN
        3'd4: begin
          red_d   = {2{checker_c}};
          green_d = {2{checker_c}};
          blue_d  = {2{checker_c}};
        end
`endif
        default: ;
      endcase
    end
  end

  // Registered colour outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign bus.Red         = red_q;
  assign bus.Green       = green_q;
  assign bus.Blue        = blue_q;
  assign bus.pattern_idx = pattern_idx_q;
  assign bus.running     = running_q;

endmodule
